// File: rtl/div_shift_left.sv
// Iterative signed divider: shifts {R,Q} left one bit per cycle and applies a
// non-restoring add/subtract step, then fixes up signs and pulses ready.
module div_shift_left #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_quotient,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             sa, sb, dz;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   r, d;

  logic             b_zero;
  logic [WIDTH-1:0] abs_a, q_fix, r_fix_lo, rem_fix;
  logic [WIDTH:0]   abs_b, s, r_step;

  always_comb begin
    // |A| only needs WIDTH bits: -2^(W-1) negates to itself, which read
    // unsigned is exactly 2^(W-1). The divisor keeps the extra bit.
    abs_a    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    abs_b    = data_operandB[WIDTH-1] ? -{1'b1, data_operandB} : {1'b0, data_operandB};
    b_zero   = (data_operandB == '0);
    s        = {r[WIDTH-1:0], q[WIDTH-1]};
    r_step   = r[WIDTH] ? s + d : s - d;
    r_fix_lo = r[WIDTH] ? r[WIDTH-1:0] + d[WIDTH-1:0] : r[WIDTH-1:0];
    q_fix    = (sa ^ sb) ? -q : q;
    rem_fix  = sa ? -r_fix_lo : r_fix_lo;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = IDLE;
      ITER: if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = dz ? DONE : IDLE;
      default: state_nxt = IDLE;
    endcase
    // A new start always wins, aborting whatever is in flight.
    if (ctrl_DIV) state_nxt = b_zero ? DONE : ITER;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt            <= '0;
      sa             <= 1'b0;
      sb             <= 1'b0;
      dz             <= 1'b0;
      q              <= '0;
      r              <= '0;
      d              <= '0;
      data_quotient  <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else if (ctrl_DIV) begin
      sa             <= data_operandA[WIDTH-1];
      sb             <= data_operandB[WIDTH-1];
      q              <= abs_a;
      d              <= abs_b;
      r              <= '0;
      cnt            <= '0;
      dz             <= b_zero;
      busy           <= ~b_zero;
      data_resultRDY <= 1'b0;
    end else begin
      case (state)
        ITER: begin
          r   <= r_step;
          q   <= {q[WIDTH-2:0], ~r_step[WIDTH]};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          data_quotient  <= q_fix;
          data_remainder <= rem_fix;
          data_exception <= 1'b0;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
        end
        DONE: begin
          // Divide-by-zero parks here one cycle to publish its result.
          if (dz) begin
            data_quotient  <= '0;
            data_remainder <= '0;
            data_exception <= 1'b1;
            data_resultRDY <= 1'b1;
            dz             <= 1'b0;
          end else begin
            data_resultRDY <= 1'b0;
          end
        end
        default: data_resultRDY <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_shift_left.sv
// Directed + random bench for div_shift_left; expected results go through a
// scoreboard queue and are compared when the ready pulse appears.
module tb_div_shift_left;

  logic        clock = 1'b0;
  logic        reset, ctrl_DIV;
  logic [31:0] opA, opB, quot, rem;
  logic        exc, rdy, busy;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        exc;
    int          lat;
  } exp_t;

  exp_t scb[$];

  div_shift_left #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .ctrl_DIV(ctrl_DIV),
    .data_operandA(opA), .data_operandB(opB),
    .data_quotient(quot), .data_remainder(rem),
    .data_exception(exc), .data_resultRDY(rdy), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint la, lb, lq, lr;
    if (b == 32'd0) begin
      e.q = '0; e.r = '0; e.exc = 1'b1; e.lat = 1;
    end else begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      lq = la / lb;
      lr = la % lb;
      e.q = lq[31:0]; e.r = lr[31:0]; e.exc = 1'b0; e.lat = 33;
    end
    return e;
  endfunction

  // Strobe for exactly one rising edge; returns #1 after that edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_DIV = 1'b1; opA = a; opB = b;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
  endtask

  task automatic push(input logic [31:0] q, input logic [31:0] r, input logic e, input int lat);
    exp_t x;
    x.q = q; x.r = r; x.exc = e; x.lat = lat;
    scb.push_back(x);
  endtask

  task automatic collect(input string tag, input bit tail);
    exp_t e;
    int   k;
    bit   busy_ok;
    e = scb.pop_front();
    k = 0;
    busy_ok = 1'b1;
    while (rdy !== 1'b1 && k < 100) begin
      if (busy !== (e.lat > 1)) busy_ok = 1'b0;
      @(posedge clock); #1;
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'(e.lat));
    chk({tag, "_q"}, quot, e.q);
    chk({tag, "_r"}, rem, e.r);
    chk({tag, "_exc"}, {31'd0, exc}, {31'd0, e.exc});
    chk({tag, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "_busy_at_rdy"}, {31'd0, busy}, 32'd0);
    if (tail) begin
      @(posedge clock); #1;
      chk({tag, "_rdy_drop"}, {31'd0, rdy}, 32'd0);
    end
  endtask

  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] q, input logic [31:0] r, input logic e, input bit tail);
    push(q, r, e, (b == 32'd0) ? 1 : 33);
    launch(a, b);
    collect(tag, tail);
  endtask

  initial begin
    bit          early;
    logic [31:0] ra, rb;
    exp_t        m;

    reset = 1'b1; ctrl_DIV = 1'b0; opA = '0; opB = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_q", quot, 32'd0);
    chk("rst_r", rem, 32'd0);
    chk("rst_exc", {31'd0, exc}, 32'd0);
    chk("rst_rdy", {31'd0, rdy}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clock); reset = 1'b0;

    op("p100_7",   32'd100,   32'd7,    32'd14,  32'd2,  1'b0, 1'b1);
    op("n100_7",   -32'sd100, 32'd7,    -32'sd14, -32'sd2, 1'b0, 1'b1);
    op("p100_n7",  32'd100,   -32'sd7,  -32'sd14, 32'd2,  1'b0, 1'b1);
    op("n100_n7",  -32'sd100, -32'sd7,  32'd14,  -32'sd2, 1'b0, 1'b1);
    op("zero_5",   32'd0,     32'd5,    32'd0,   32'd0,  1'b0, 1'b1);
    op("p7_100",   32'd7,     32'd100,  32'd0,   32'd7,  1'b0, 1'b1);
    op("div0",     32'd5,     32'd0,    32'd0,   32'd0,  1'b1, 1'b1);
    op("ovf",      32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
    op("min_1",    32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0, 1'b0, 1'b1);
    op("max_min",  32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 1'b0, 1'b1);

    // Restart while busy: only the second operation reports.
    early = 1'b0;
    launch(32'd1000, 32'd3);
    repeat (9) begin
      @(posedge clock); #1;
      if (rdy === 1'b1) early = 1'b1;
    end
    push(32'd9, 32'd0, 1'b0, 33);
    launch(32'd81, 32'd9);
    chk("restart_no_early", {31'd0, early}, 32'd0);
    collect("restart", 1'b1);

    // Start lands on the edge that would have raised ready.
    launch(32'd100, 32'd7);
    repeat (32) begin @(posedge clock); #1; end
    push(32'd7, 32'd2, 1'b0, 33);
    launch(32'd51, 32'd7);
    collect("same_edge", 1'b1);

    // Start while the previous result is being presented.
    op("pre_done", 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 1'b0);
    op("in_done",  -32'sd9, 32'd4, -32'sd2, -32'sd1, 1'b0, 1'b1);

    // Reset mid-operation.
    launch(32'd1000, 32'd3);
    repeat (14) begin @(posedge clock); #1; end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    chk("midrst_q", quot, 32'd0);
    chk("midrst_r", rem, 32'd0);
    chk("midrst_exc", {31'd0, exc}, 32'd0);
    chk("midrst_rdy", {31'd0, rdy}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clock); reset = 1'b0;
    early = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (rdy !== 1'b0 || busy !== 1'b0) early = 1'b1;
    end
    chk("midrst_quiet", {31'd0, early}, 32'd0);
    op("after_rst", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : $urandom_range(1, 300);
      if (i == 5) rb = -rb;
      m = model(ra, rb);
      push(m.q, m.r, m.exc, m.lat);
      launch(ra, rb);
      collect("rand", 1'b1);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
